// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock parametrised FIFO: read-mode
// constants, count width and the parameter legality rule.
package sync_fifo_pkg;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  // count must represent 0..DEPTH inclusive, hence one bit beyond the address.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit params_legal(input int data_w, input int depth,
                                      input int af_thresh, input int ae_thresh,
                                      input int fwft);
    return (data_w >= 1) &&
           (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh >= 0) && (ae_thresh <= depth - 1) &&
           ((fwft == MODE_STD) || (fwft == MODE_FWFT));
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Port bundle of the single-clock FIFO; the producer/consumer side is master,
// the FIFO itself is slave.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  import sync_fifo_pkg::*;

  localparam int CW = count_width(DEPTH);

  // Request semantics: wr_en/rd_en are requests, not handshakes. A write is
  // taken when wr_en & (!full | rd_en), a read when rd_en & !empty; any
  // request that is not taken leaves state untouched and raises overflow or
  // underflow for the following cycle only.
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;
  logic [CW-1:0]     count;

  modport master (
    output wr_en, din, rd_en,
    input  dout, full, empty, almost_full, almost_empty,
           overflow, underflow, count
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, full, empty, almost_full, almost_empty,
           overflow, underflow, count
  );

endinterface

// File: rtl/fifo_regfile.sv
// DEPTH x DATA_W storage array: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
module fifo_regfile #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered or first-word-fall-through
// read data, fill level, almost flags and overflow/underflow pulses.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = MODE_STD
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave f
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  if (!params_legal(DATA_W, DEPTH, AF_THRESH, AE_THRESH, FWFT)) begin : g_param_check
    $error("sync_fifo_param: illegal parameter set");
  end

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic              ovf_q;
  logic              unf_q;
  logic              full_c;
  logic              empty_c;
  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] rd_data;

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);
  assign rd_ok   = f.rd_en & ~empty_c;
  // When full, a concurrent accepted read frees the slot this write lands in.
  assign wr_ok   = f.wr_en & (~full_c | f.rd_en);

  // Reset dominates: a write in the reset cycle must not land in storage.
  fifo_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (wr_ok & ~rst),
    .waddr (wr_ptr),
    .wdata (f.din),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      ovf_q <= f.wr_en & ~wr_ok;
      unf_q <= f.rd_en & ~rd_ok;
    end
  end

  if (FWFT == MODE_FWFT) begin : g_fwft
    assign f.dout = rd_data;
  end else begin : g_std
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
      end else if (rd_ok) begin
        dout_q <= rd_data;
      end
    end

    assign f.dout = dout_q;
  end

  assign f.count        = count_q;
  assign f.full         = full_c;
  assign f.empty        = empty_c;
  assign f.almost_full  = (count_q >= CW'(AF_THRESH));
  assign f.almost_empty = (count_q <= CW'(AE_THRESH));
  assign f.overflow     = ovf_q;
  assign f.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one registered-read instance and one
// FWFT instance, each tracked by a reference queue and count model.
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  // reference models
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_fq[$];
  int            ma_count;
  logic [DW-1:0] ma_dout;
  int            mb_count;

  sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DP)) a_if ();
  sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DP)) b_if ();

  sync_fifo_param #(
    .DATA_W(DW), .DEPTH(DP), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
  ) dut_std (
    .clk (clk),
    .rst (rst),
    .f   (a_if)
  );

  sync_fifo_param #(
    .DATA_W(DW), .DEPTH(DP), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
  ) dut_fwft (
    .clk (clk),
    .rst (rst),
    .f   (b_if)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_std(input bit exp_ovf, input bit exp_unf);
    check("std_count",  32'(a_if.count),        32'(ma_count));
    check("std_full",   32'(a_if.full),         32'(ma_count == DP));
    check("std_empty",  32'(a_if.empty),        32'(ma_count == 0));
    check("std_afull",  32'(a_if.almost_full),  32'(ma_count >= AF));
    check("std_aempty", 32'(a_if.almost_empty), 32'(ma_count <= AE));
    check("std_ovf",    32'(a_if.overflow),     32'(exp_ovf));
    check("std_unf",    32'(a_if.underflow),    32'(exp_unf));
    check("std_dout",   32'(a_if.dout),         32'(ma_dout));
  endtask

  task automatic check_fw(input bit exp_ovf, input bit exp_unf);
    check("fw_count", 32'(b_if.count),     32'(mb_count));
    check("fw_full",  32'(b_if.full),      32'(mb_count == DP));
    check("fw_empty", 32'(b_if.empty),     32'(mb_count == 0));
    check("fw_ovf",   32'(b_if.overflow),  32'(exp_ovf));
    check("fw_unf",   32'(b_if.underflow), 32'(exp_unf));
    if (mb_count > 0) check("fw_dout", 32'(b_if.dout), 32'(exp_fq[0]));
  endtask

  // driver: one cycle on the registered-read instance
  task automatic op_std(input bit w, input logic [DW-1:0] d, input bit r);
    bit wa;
    bit ra;
    wa = w && ((ma_count < DP) || r);
    ra = r && (ma_count > 0);
    if (wa) exp_q.push_back(d);
    if (ra) ma_dout = exp_q.pop_front();
    ma_count = ma_count + int'(wa) - int'(ra);
    a_if.wr_en = w;
    a_if.din   = d;
    a_if.rd_en = r;
    @(posedge clk); #1;
    a_if.wr_en = 1'b0;
    a_if.rd_en = 1'b0;
    check_std(w && !wa, r && !ra);
  endtask

  // driver: one cycle on the FWFT instance
  task automatic op_fw(input bit w, input logic [DW-1:0] d, input bit r);
    bit wa;
    bit ra;
    logic [DW-1:0] popped;
    wa = w && ((mb_count < DP) || r);
    ra = r && (mb_count > 0);
    if (wa) exp_fq.push_back(d);
    if (ra) popped = exp_fq.pop_front();
    mb_count = mb_count + int'(wa) - int'(ra);
    b_if.wr_en = w;
    b_if.din   = d;
    b_if.rd_en = r;
    @(posedge clk); #1;
    b_if.wr_en = 1'b0;
    b_if.rd_en = 1'b0;
    check_fw(w && !wa, r && !ra);
  endtask

  task automatic apply_reset(input bit w, input bit r);
    rst        = 1'b1;
    a_if.wr_en = w;
    a_if.rd_en = r;
    a_if.din   = 8'hE1;
    b_if.wr_en = w;
    b_if.rd_en = r;
    b_if.din   = 8'hE2;
    @(posedge clk); #1;
    rst        = 1'b0;
    a_if.wr_en = 1'b0;
    a_if.rd_en = 1'b0;
    b_if.wr_en = 1'b0;
    b_if.rd_en = 1'b0;
    exp_q.delete();
    exp_fq.delete();
    ma_count = 0;
    ma_dout  = '0;
    mb_count = 0;
    check_std(1'b0, 1'b0);
    check_fw(1'b0, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    a_if.wr_en = 1'b0;
    a_if.rd_en = 1'b0;
    a_if.din   = '0;
    b_if.wr_en = 1'b0;
    b_if.rd_en = 1'b0;
    b_if.din   = '0;
    ma_count   = 0;
    ma_dout    = '0;
    mb_count   = 0;

    apply_reset(1'b0, 1'b0);
    apply_reset(1'b0, 1'b0);

    // fill with 0x01..0x10, flags tracked every cycle
    for (int i = 1; i <= DP; i++) op_std(1'b1, 8'(i), 1'b0);

    // overflow on full, then pulse must drop while draining in order
    op_std(1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < DP; i++) op_std(1'b0, 8'h00, 1'b1);

    // underflow on empty, dout holds 0x10
    op_std(1'b0, 8'h00, 1'b1);
    op_std(1'b0, 8'h00, 1'b0);

    // empty with simultaneous write and read
    op_std(1'b1, 8'h99, 1'b1);
    op_std(1'b0, 8'h00, 1'b1);

    // full with simultaneous write 0x55 and read
    for (int i = 0; i < DP; i++) op_std(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    op_std(1'b1, 8'h55, 1'b1);
    for (int i = 0; i < DP; i++) op_std(1'b0, 8'h00, 1'b1);

    // sustained back-to-back traffic across pointer wrap
    for (int i = 0; i < 8; i++) op_std(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 40; i++) op_std(1'b1, 8'($urandom_range(0, 255)), 1'b1);

    // random mix
    for (int i = 0; i < 60; i++)
      op_std(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    // FWFT instance
    op_fw(1'b1, 8'h3C, 1'b0);
    op_fw(1'b0, 8'h00, 1'b1);
    op_fw(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) op_fw(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 30; i++) op_fw(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 14; i++) op_fw(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    op_fw(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < DP + 1; i++) op_fw(1'b0, 8'h00, 1'b1);

    // reset mid-operation with requests active
    apply_reset(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) op_std(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 10; i++) op_fw(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    apply_reset(1'b1, 1'b1);
    op_std(1'b0, 8'h00, 1'b0);
    op_std(1'b1, 8'h77, 1'b0);
    op_std(1'b0, 8'h00, 1'b1);
    op_fw(1'b1, 8'h77, 1'b0);
    op_fw(1'b0, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO; the synchronous-domain successor to the team's asynchronous FIFO. It keeps the same port vocabulary and status set (full/empty, almost flags, overflow/underflow) and adds configurable width, depth and almost-flag thresholds, a fill-level output, and a selectable first-word-fall-through (FWFT) read mode. It is used inside a single clock domain, for example as a buffer between the streaming stages feeding or draining the async FIFO.

## Interface
- DATA_W, 8, data width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH; legal range 1..DEPTH
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through

- clk  in  1  single clock, all logic on its rising edge
- rst  in  1  reset; synchronous and active-high
- wr_en  in  1  write request
- din  in  DATA_W  write data
- rd_en  in  1  read / pop request
- dout  out  DATA_W  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- overflow  out  1  one-cycle pulse: a write was rejected
- underflow  out  1  one-cycle pulse: a read was rejected
- count  out  $clog2(DEPTH)+1  number of stored words

## Operation
- State:
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits; they wrap modulo DEPTH with no extra logic.
  - count is a registered value.
  - Storage is a register array; it is not cleared by reset.
- Write accepted = wr_en & (!full | rd_en). A write when full is accepted only if a read is also accepted in the same cycle.
- Read accepted = rd_en & !empty.
- Rejected write: no state change; overflow pulses.
- Rejected read: no state change; underflow pulses.
- count update: +1 on a write only, −1 on a read only, unchanged when both or neither are accepted.
- Full with wr_en and rd_en in the same cycle: both accepted, count stays DEPTH, no overflow.
- Empty with wr_en and rd_en in the same cycle: the write is accepted, the read is rejected, underflow pulses, count becomes 1.
- FWFT=0: dout is a register. On an accepted read it loads mem[rd_ptr] at the edge; otherwise it holds its value.
- FWFT=1: dout = mem[rd_ptr] combinationally. It is valid whenever empty=0 and is undefined (don't-care) when empty=1. An accepted read advances rd_ptr.
- Status flags are combinational decodes of the registered count.
- Reset values:
  - count=0, dout=0, full=0, empty=1.
  - almost_full=0, provided AF_THRESH≥1.
  - almost_empty=1.
  - overflow=0, underflow=0.
  - Both pointers = 0.
- Reset mid-operation: rst dominates. Any wr_en/rd_en in the reset cycle is ignored and no pulse is generated. All stored content is logically discarded.
- Illegal parameter values are caught by an elaboration-time check that raises $error.

## Timing
- Write latency: din is captured at edge N; count, empty and almost flags update after edge N.
- FWFT=1 write-to-read: data written at edge N appears on dout immediately after edge N.
- FWFT=0 read latency: rd_en sampled at edge N; dout is valid after edge N.
- overflow/underflow: high for exactly the cycle following the offending edge.
- Back-to-back operation: one write and one read per cycle are sustained indefinitely, with no bubbles.
- Pointer wrap (DEPTH-1 → 0) must produce no flag glitch and no data corruption.

## Structure
- Package sync_fifo_pkg holds:
  - the count-width function (clog2(DEPTH)+1);
  - the FWFT mode constants (MODE_STD=0, MODE_FWFT=1);
  - the shared parameter-legality check.
- One natural sub-module: fifo_regfile. It is a DEPTH×DATA_W register array with a single write port and an asynchronous read port.
- The top level holds the pointers, count, flags, pulse generation and the dout register.

## Test plan
All scenarios use DATA_W=8, DEPTH=16, AF_THRESH=14, AE_THRESH=2.
- Reset, then write 0x01..0x10 on consecutive cycles → count reaches 16, almost_full from count=14, full at 16, almost_empty drops at count=3.
- Full FIFO, write 0xAA → overflow pulses for 1 cycle, count stays 16; then read all 16 (FWFT=0) → dout is 0x01..0x10 in order, one cycle after each rd_en; empty at end.
- Empty FIFO, rd_en=1 → underflow pulses, dout holds its previous value, count=0.
- Full FIFO, simultaneous write 0x55 and read → no overflow, count=16, 0x55 emerges last after 16 further reads.
- FWFT=1: write 0x3C into empty → dout=0x3C right after the write edge and empty=0; rd_en pops it → empty=1.
- Fill to 10, assert rst for one cycle together with wr_en/rd_en → count=0, empty=1, no pulses; write 0x77 then read → 0x77 returned, confirming pointers restarted at 0.
